muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 mult_start  input  1  request a signed MULT of op_a*op_b, sampled on clk.
REQ-005 div_start  input  1  request a signed DIV of op_a/op_b, sampled on clk.
REQ-006 op_a  input  32  multiplicand or dividend, sampled with the accepted start.
REQ-007 op_b  input  32  multiplier or divisor, sampled with the accepted start.
REQ-008 busy  output  1  high while an operation is in progress; the control unit stalls on it.
REQ-009 done  output  1  one-cycle pulse marking completion.
REQ-010 hi_lo_we  output  1  one-cycle write-enable pulse for the HI/LO registers.
REQ-011 hi  output  32  MULT upper product or DIV remainder.
REQ-012 lo  output  32  MULT lower product or DIV quotient.
REQ-013 div_zero  output  1  one-cycle divide-by-zero flag pulse.

Function
REQ-014 The FSM SHALL have four states: IDLE, MULT, DIV and DONE.
REQ-015 Operations SHALL be accepted only in IDLE; a start asserted in any other state SHALL be ignored and not queued.
REQ-016 In IDLE, mult_start SHALL transition to MULT, and div_start alone SHALL transition to DIV.
- If both are high in the same cycle, MULT SHALL win and div_start SHALL be dropped.
REQ-017 On acceptance in cycle T, the block SHALL latch operand magnitudes and result signs and load a 5-bit iteration counter with 0.
REQ-018 MULT SHALL perform one shift-add iteration per cycle, T+1 through T+32.
REQ-019 DIV SHALL perform one restoring shift-subtract iteration per cycle, T+1 through T+32.
REQ-020 The transition to DONE SHALL occur when the counter wraps from 31 to 0, so DONE is occupied in cycle T+33.
REQ-021 In DONE, the block SHALL apply sign correction, update hi/lo, pulse done and hi_lo_we for exactly one cycle, and return to IDLE.
REQ-022 MULT SHALL produce the signed 64-bit product: hi = bits 63:32, lo = bits 31:0.
REQ-023 DIV SHALL truncate the quotient toward zero (lo), and the remainder (hi) SHALL take the sign of the dividend.
REQ-024 The 0x80000000 / 0xFFFFFFFF case SHALL give lo = 0x80000000, hi = 0.
REQ-025 busy SHALL be high in MULT, DIV and DONE, and low only in IDLE; the earliest next acceptance is therefore T+34.
REQ-026 hi and lo SHALL hold their last written values until the next DONE; intermediate iterations SHALL NOT be visible on hi/lo.
REQ-027 done, hi_lo_we and div_zero SHALL never be asserted outside the cycle in which they pulse.

Reset
REQ-028 While reset is high at a rising clk edge, the block SHALL enter IDLE, and busy, done, hi_lo_we and div_zero SHALL be 0.
REQ-029 The same reset SHALL clear hi, lo and all internal registers to 0, and reset SHALL have priority over any start.
REQ-030 Reset mid-operation SHALL abort the operation with no done, hi_lo_we or hi/lo update.
- The first start SHALL be accepted in the first cycle with reset low.

Configuration
REQ-031 The macro MULDIV_DIV_ZERO_EXC_EN SHALL control divide-by-zero handling.
REQ-032 With MULDIV_DIV_ZERO_EXC_EN defined, a DIV accepted with op_b = 0 SHALL go directly to DONE at T+1.
- It SHALL pulse div_zero and done at T+1 with hi_lo_we = 0, and hi/lo SHALL be unchanged.
REQ-033 Without MULDIV_DIV_ZERO_EXC_EN, div_zero SHALL be tied to 0.
- A DIV with op_b = 0 SHALL run the full 32 iterations, and DONE at T+33 SHALL write lo = 0xFFFFFFFF and hi = op_a, with sign correction bypassed.

Verification
REQ-034 Basic MULT: mult_start with 7 * 6 at T -> busy T+1..T+33; done and hi_lo_we at T+33; lo = 0x0000002A, hi = 0.
REQ-035 Signed MULT: -3 * 5 -> at T+33, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
REQ-036 Signed DIV: -7 / 2 -> at T+33, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-037 Simultaneous start and start-while-busy: mult_start and div_start together with 3, 4 -> lo = 12.
- div_start pulsed at T+5 -> ignored, and only one done is seen.
REQ-038 Reset mid-operation: reset at T+10 during MULT -> busy = 0 at T+11, no done, hi/lo = 0; a new MULT 2*2 at T+12 gives lo = 4 at T+45.
REQ-039 Divide by zero: 9 / 0 -> with the macro, div_zero and done at T+1 with hi/lo unchanged.
- Without the macro, done at T+33 with lo = 0xFFFFFFFF, hi = 9.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Iterative signed 32x32 multiply / divide unit: shift-add MULT and restoring DIV, 32 cycles each.
// Optional build macro MULDIV_DIV_ZERO_EXC_EN: short-circuit DIV by zero with a div_zero pulse.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             hi_lo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic neg, input logic signed [WIDTH-1:0] v);
        return neg ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic neg, input logic signed [2*WIDTH-1:0] v);
        return neg ? (2*WIDTH)'(-v) : (2*WIDTH)'(v);
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             neg_lo_q, neg_lo_d;
    logic             is_div_q, is_div_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   corr_hi, corr_lo;
    logic               in_done, dz_event, we;

    assign in_done = (state_q == DONE);
`ifdef MULDIV_DIV_ZERO_EXC_EN
    assign dz_event = in_done && is_div_q && bzero_q;
`else
    assign dz_event = 1'b0;
`endif
    assign we       = in_done && !dz_event;
    assign busy     = (state_q != IDLE);
    assign done     = in_done;
    assign hi_lo_we = we;
    assign div_zero = dz_event;

    // Result is presented combinationally during DONE, then held in hi_q/lo_q
    assign hi = we ? corr_hi : hi_q;
    assign lo = we ? corr_lo : lo_q;

    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        prod_fix  = neg_2w(neg_hi_q, {work_hi_q, work_lo_q});
        if (is_div_q) begin
            // Divide by zero leaves the all-ones quotient uncorrected
            corr_lo = bzero_q ? {WIDTH{1'b1}} : neg_w(neg_lo_q, work_lo_q);
            corr_hi = neg_w(neg_hi_q, work_hi_q);
        end else begin
            corr_hi = prod_fix[2*WIDTH-1:WIDTH];
            corr_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        neg_hi_d  = neg_hi_q;
        neg_lo_d  = neg_lo_q;
        is_div_d  = is_div_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (mult_start) begin
                    state_d   = MULT;
                    cnt_d     = 5'd0;
                    mag_a_d   = mag(op_a);
                    work_hi_d = '0;
                    work_lo_d = mag(op_b);
                    neg_hi_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    neg_lo_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    is_div_d  = 1'b0;
                    bzero_d   = 1'b0;
                end else if (div_start) begin
                    state_d   = DIV;
                    cnt_d     = 5'd0;
                    mag_b_d   = mag(op_b);
                    work_hi_d = '0;
                    work_lo_d = mag(op_a);
                    neg_hi_d  = op_a[WIDTH-1];
                    neg_lo_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    is_div_d  = 1'b1;
                    bzero_d   = (op_b == '0);
`ifdef MULDIV_DIV_ZERO_EXC_EN
                    if (op_b == '0) state_d = DONE;
`endif
                end
            end
            MULT: begin
                {work_hi_d, work_lo_d} = {mul_sum, work_lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DONE;
            end
            DIV: begin
                // Restoring step: quotient bits shift in at the bottom of work_lo
                if (div_shift >= {1'b0, mag_b_q}) begin
                    work_hi_d = div_diff[WIDTH-1:0];
                    work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    work_hi_d = div_shift[WIDTH-1:0];
                    work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (we) begin
                    hi_d = corr_hi;
                    lo_d = corr_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            neg_hi_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            is_div_q  <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            neg_hi_q  <= neg_hi_d;
            neg_lo_q  <= neg_lo_d;
            is_div_q  <= is_div_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; honours MULDIV_DIV_ZERO_EXC_EN when the design is built with it.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start, div_start;
    logic [31:0] op_a, op_b;
    logic        busy, done, hi_lo_we, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi_lo_we(hi_lo_we),
        .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start in the current cycle T and follow the operation through T+34
    task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        mult_start = !is_div;
        div_start  = is_div;
        op_a = a;
        op_b = b;
        step();
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h1234_5678;
        chk({tag, " busy@T+1"}, 32'(busy), 32'd1);
        repeat (31) step();
        chk({tag, " done@T+32"}, 32'(done), 32'd0);
        chk({tag, " busy@T+32"}, 32'(busy), 32'd1);
        step();
        chk({tag, " done@T+33"}, 32'(done), 32'd1);
        chk({tag, " we@T+33"}, 32'(hi_lo_we), 32'd1);
        chk({tag, " dz@T+33"}, 32'(div_zero), 32'd0);
        chk({tag, " hi@T+33"}, hi, exp_hi);
        chk({tag, " lo@T+33"}, lo, exp_lo);
        step();
        chk({tag, " busy@T+34"}, 32'(busy), 32'd0);
        chk({tag, " done@T+34"}, 32'(done), 32'd0);
        chk({tag, " hi held"}, hi, exp_hi);
        chk({tag, " lo held"}, lo, exp_lo);
    endtask

    initial begin
        int ndone;
        logic [31:0] cap_lo;
        reset = 1'b1;
        mult_start = 1'b1;
        div_start = 1'b1;
        op_a = 32'd5;
        op_b = 32'd5;
        step();
        step();
        mult_start = 1'b0;
        div_start = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset we", 32'(hi_lo_we), 32'd0);
        chk("reset dz", 32'(div_zero), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b0;

        run_op("mul 7*6", 0, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A);
        run_op("mul -3*5", 0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mul max*max", 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        run_op("mul min*min", 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div -7/2", 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 100/7", 1, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div -100/7", 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        run_op("div 100/-7", 1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
        run_op("div min/-1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Both starts together, then a div_start while busy at T+5
        mult_start = 1'b1;
        div_start = 1'b1;
        op_a = 32'd3;
        op_b = 32'd4;
        step();
        mult_start = 1'b0;
        div_start = 1'b0;
        repeat (4) step();
        div_start = 1'b1;
        op_a = 32'd100;
        op_b = 32'd1;
        step();
        div_start = 1'b0;
        ndone = 0;
        cap_lo = 32'hFFFF_FFFF;
        for (int i = 0; i < 35; i++) begin
            if (done) begin
                ndone++;
                cap_lo = lo;
            end
            step();
        end
        chk("both-start done count", 32'(ndone), 32'd1);
        chk("both-start lo", cap_lo, 32'd12);
        chk("both-start busy after", 32'(busy), 32'd0);

        // Reset at T+10 during MULT
        mult_start = 1'b1;
        op_a = 32'd5;
        op_b = 32'd5;
        step();
        mult_start = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        step();
        run_op("mul 2*2 after abort", 0, 32'd2, 32'd2, 32'd0, 32'd4);

`ifdef MULDIV_DIV_ZERO_EXC_EN
        div_start = 1'b1;
        op_a = 32'd9;
        op_b = 32'd0;
        step();
        div_start = 1'b0;
        chk("dz pulse", 32'(div_zero), 32'd1);
        chk("dz done", 32'(done), 32'd1);
        chk("dz we", 32'(hi_lo_we), 32'd0);
        chk("dz hi", hi, 32'd0);
        chk("dz lo", lo, 32'd4);
        step();
        chk("dz busy after", 32'(busy), 32'd0);
        chk("dz clear", 32'(div_zero), 32'd0);
        chk("dz lo held", lo, 32'd4);
`else
        run_op("div 9/0", 1, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
        run_op("div -9/0", 1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
